// File: rtl/wavetable_loader_pkg.sv
// wavetable_loader_pkg: shared defaults, FSM state encoding and bank type for the wavetable loader.
// Contents:
//   DATAWIDTH_DEF / ADDRWIDTH_DEF  default sample width and table address width
//   SUMWIDTH                       width of the optional table checksum
//   state_t                        loader FSM encoding (IDLE, LOAD, CHECK, COMMIT)
//   bank_t                         2-bit wavetable bank number
package wavetable_loader_pkg;
    localparam int DATAWIDTH_DEF = 16;
    localparam int ADDRWIDTH_DEF = 8;
    localparam int SUMWIDTH = 16;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;
    typedef logic [1:0] bank_t;
endpackage

// File: rtl/wavetable_loader_if.sv
// wavetable_loader_if: upstream sample stream into the wavetable loader.
// Signals:
//   s_valid  upstream sample valid
//   s_ready  loader can take the beat (beat moves when s_valid & s_ready at a rising edge)
//   s_data   sample, or checksum word in the CHECK phase
//   s_first  beat is sample 0 of a new table
//   s_bank   target bank, only meaningful on s_first beats
// Modports: master = sample source, slave = loader.
interface wavetable_loader_if import wavetable_loader_pkg::*; #(
    parameter int DATAWIDTH = DATAWIDTH_DEF
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATAWIDTH-1:0] s_data;
    logic                 s_first;
    bank_t                s_bank;
    modport master (output s_valid, s_data, s_first, s_bank, input s_ready);
    modport slave  (input s_valid, s_data, s_first, s_bank, output s_ready);
endinterface

// File: rtl/wavetable_loader_checksum.sv
// wt_checksum: modulo 2^SUMWIDTH accumulator for the table checksum.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         restart the sum (combined with add, the sum restarts at din)
//   add         add din into the sum
//   din         value to accumulate
//   sum         running sum
module wt_checksum import wavetable_loader_pkg::*; (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                add,
    input  logic [SUMWIDTH-1:0] din,
    output logic [SUMWIDTH-1:0] sum
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (clr || add)
            sum <= (clr ? '0 : sum) + (add ? din : '0);
    end
endmodule

// File: rtl/wavetable_loader.sv
// wavetable_loader: streams one wavetable into a RAM bank and switches the active bank on commit.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   src              sample stream (wavetable_loader_if.slave)
//   WADDR/wbank      RAM write address and bank
//   WDATA/WE         RAM write data and strobe, one cycle per accepted sample
//   active_bank      bank the wavetable reader uses
//   busy             high in LOAD, CHECK, COMMIT
//   done / err       one-cycle pulses on commit / on a rejected or aborted table
// Build option: WAVETABLE_LOADER_CHECKSUM_EN adds a CHECK phase that compares one trailing
// checksum beat against the 16-bit sum of the table samples before committing.
module wavetable_loader import wavetable_loader_pkg::*; #(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wavetable_loader_if.slave    src,
    output logic [ADDRWIDTH-1:0] WADDR,
    output bank_t                wbank,
    output logic [DATAWIDTH-1:0] WDATA,
    output logic                 WE,
    output bank_t                active_bank,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHECK;
`else
    localparam state_t AFTER_LAST = COMMIT;
`endif
    state_t               state, nxt;
    logic                 ready, accept, start, open_ok, seq, last, chk, match, fail;
    logic [ADDRWIDTH-1:0] waddr_inc;
    assign src.s_ready = ready;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    logic [SUMWIDTH-1:0] sum;
    wt_checksum u_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .add   (open_ok || seq),
        .din   (SUMWIDTH'(src.s_data)),
        .sum   (sum)
    );
    assign match = sum == SUMWIDTH'(src.s_data);
`else
    assign match = 1'b0;
`endif
    always_comb begin
        accept    = src.s_valid && ready;
        // s_first restarts a table from any state that can accept (IDLE, LOAD, CHECK)
        start     = accept && src.s_first;
        open_ok   = start && src.s_bank != active_bank;
        seq       = accept && !src.s_first && state == LOAD;
        waddr_inc = WADDR + 1'b1;
        last      = seq && &waddr_inc;
        chk       = accept && !src.s_first && state == CHECK;
        nxt       = start ? (open_ok ? LOAD : IDLE)
                  : seq ? (last ? AFTER_LAST : LOAD)
                  : chk ? (match ? COMMIT : IDLE)
                  : state == COMMIT ? IDLE : state;
        // a restart outside IDLE aborts the table in flight; writing the live bank is refused
        fail      = (start && (!open_ok || state != IDLE)) || (chk && !match);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            WE          <= 1'b0;
            WADDR       <= '0;
            wbank       <= '0;
            WDATA       <= '0;
            active_bank <= '0;
        end else begin
            state <= nxt;
            ready <= nxt != COMMIT;
            busy  <= nxt != IDLE;
            done  <= state == COMMIT;
            err   <= fail;
            WE    <= open_ok || seq;
            if (open_ok || seq) begin
                WADDR <= open_ok ? '0 : waddr_inc;
                WDATA <= src.s_data;
            end
            if (open_ok)
                wbank <= src.s_bank;
            if (state == COMMIT)
                active_bank <= wbank;
        end
    end
endmodule

// File: tb/tb_wavetable_loader.sv
// tb_wavetable_loader: directed self-checking bench for wavetable_loader.
module tb_wavetable_loader;
    import wavetable_loader_pkg::*;
    localparam int DW = 16;
    localparam int AW = 8;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] waddr;
    bank_t         wbank, active_bank;
    logic [DW-1:0] wdata;
    logic          we, busy, done, err;
    int            checks = 0;
    int            errors = 0;
    logic [15:0]   s;
    always #5 clk = ~clk;
    wavetable_loader_if #(.DATAWIDTH(DW)) bus ();
    wavetable_loader #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src         (bus.slave),
        .WADDR       (waddr),
        .wbank       (wbank),
        .WDATA       (wdata),
        .WE          (we),
        .active_bank (active_bank),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );
    typedef struct {
        logic        v, f;
        bank_t       b;
        logic [15:0] d;
        logic        we, er, bsy;
        logic [7:0]  a;
        bank_t       wb;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input bank_t b, input logic [15:0] d);
        @(negedge clk);
        bus.s_valid = v;
        bus.s_first = f;
        bus.s_bank  = b;
        bus.s_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic f, input bank_t b, input logic [15:0] d, input int a, input bank_t eb);
        drive(1'b1, f, b, d);
        check("we", we, 1);
        check("waddr", waddr, a);
        check("wbank", wbank, eb);
        check("wdata", wdata, d);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 2'd0, 16'h0);
        check("gap_we", we, 0);
    endtask

    task automatic finish_table(input bank_t b, input bank_t old, input logic [15:0] sm);
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        drive(1'b1, 1'b0, 2'd0, sm);
        check("chk_we", we, 0);
        check("chk_err", err, 0);
`endif
        check("commit_busy", busy, 1);
        check("commit_ready", bus.s_ready, 0);
        check("commit_done_early", done, 0);
        check("commit_active_old", active_bank, old);
        drive(1'b0, 1'b0, 2'd0, 16'h0);
        check("done", done, 1);
        check("active_bank", active_bank, b);
        check("busy_after", busy, 0);
        check("ready_after", bus.s_ready, 1);
        drive(1'b0, 1'b0, 2'd0, 16'h0);
        check("done_pulse", done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gap();
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
        bus.s_bank  = 2'd0;
        bus.s_data  = '0;
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 2'd0, 16'h1111, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0};
        tbl[3]  = '{1'b1, 1'b1, 2'd1, 16'h1234, 1'b1, 1'b0, 1'b1, 8'd0, 2'd1};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 16'h0005, 1'b1, 1'b0, 1'b1, 8'd1, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 16'h0006, 1'b1, 1'b0, 1'b1, 8'd2, 2'd1};
        tbl[7]  = '{1'b1, 1'b1, 2'd0, 16'h2222, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 16'h0007, 1'b1, 1'b0, 1'b1, 8'd0, 2'd2};
        tbl[9]  = '{1'b1, 1'b1, 2'd3, 16'h0009, 1'b1, 1'b1, 1'b1, 8'd0, 2'd3};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 16'h000A, 1'b1, 1'b0, 1'b1, 8'd1, 2'd3};
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_active", active_bank, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.s_ready, 0);
        rst_n = 1'b1;
        gap();
        check("ready_release", bus.s_ready, 1);
        // single-beat vectors from IDLE with active_bank 0
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].f, tbl[i].b, tbl[i].d);
            check($sformatf("vec%0d_we", i), we, tbl[i].we);
            check($sformatf("vec%0d_err", i), err, tbl[i].er);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            if (tbl[i].we) begin
                check($sformatf("vec%0d_waddr", i), waddr, tbl[i].a);
                check($sformatf("vec%0d_wbank", i), wbank, tbl[i].wb);
                check($sformatf("vec%0d_wdata", i), wdata, tbl[i].d);
            end
        end
        do_reset();
        // full back-to-back table into bank 1, data i*3
        s = 16'h0;
        for (int i = 0; i < 256; i++) begin
            send(i == 0, 2'd1, 16'(i * 3), i, 2'd1);
            s += 16'(i * 3);
        end
        finish_table(2'd1, 2'd0, s);
        // restart targeting the live bank is rejected
        drive(1'b1, 1'b1, 2'd1, 16'h0055);
        check("rej_we", we, 0);
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        gap();
        check("rej_err_pulse", err, 0);
        check("rej_active", active_bank, 1);
        // bank 2 with a gap after every beat
        s = 16'h0;
        for (int i = 0; i < 256; i++) begin
            send(i == 0, 2'd2, 16'(i + 16'h0100), i, 2'd2);
            s += 16'(i + 16'h0100);
            if (i != 255)
                gap();
        end
        finish_table(2'd2, 2'd1, s);
        // abort at sample 100 by a new table for bank 3
        for (int i = 0; i < 100; i++)
            send(i == 0, 2'd1, 16'(i), i, 2'd1);
        send(1'b1, 2'd3, 16'hBEEF, 0, 2'd3);
        check("abort_err", err, 1);
        check("abort_busy", busy, 1);
        s = 16'hBEEF;
        for (int i = 1; i < 256; i++) begin
            send(1'b0, 2'd3, 16'(i), i, 2'd3);
            if (i == 1)
                check("abort_err_pulse", err, 0);
            s += 16'(i);
        end
        finish_table(2'd3, 2'd2, s);
        // asynchronous reset mid-table
        for (int i = 0; i < 50; i++)
            send(i == 0, 2'd0, 16'(i + 7), i, 2'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", we, 0);
        check("arst_waddr", waddr, 0);
        check("arst_wbank", wbank, 0);
        check("arst_wdata", wdata, 0);
        check("arst_active", active_bank, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_ready", bus.s_ready, 0);
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("arst_hold_done", done, 0);
        check("arst_hold_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        gap();
        check("arst_rel_ready", bus.s_ready, 1);
        check("arst_rel_err", err, 0);
        check("arst_rel_done", done, 0);
        check("arst_rel_active", active_bank, 0);
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        // all-ones table: matching and mismatching checksum
        for (int i = 0; i < 256; i++)
            send(i == 0, 2'd1, 16'h0001, i, 2'd1);
        finish_table(2'd1, 2'd0, 16'h0100);
        for (int i = 0; i < 256; i++)
            send(i == 0, 2'd2, 16'h0001, i, 2'd2);
        drive(1'b1, 1'b0, 2'd0, 16'h00FF);
        check("bad_sum_we", we, 0);
        check("bad_sum_err", err, 1);
        check("bad_sum_busy", busy, 0);
        gap();
        check("bad_sum_done", done, 0);
        check("bad_sum_active", active_bank, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
